stack_sequencer: RTL and testbench

Command-driven controller that owns the stack pointer and sequences PUSH, POP and LOAD_SP operations onto the single-port data memory shared with the CPU datapath. The stack grows downward from 8'hFF and stops at 8'hAF, giving 80 entries. CPU datapath memory accesses always have priority, and stack accesses stall until the port is free. The block sits between the instruction decoder (command side) and the top-level data-memory mux.

---
 rtl/stack_pkg.sv | 20 ++
 rtl/stack_sequencer_if.sv | 33 +++
 rtl/stack_sp_reg.sv | 57 +++++
 rtl/stack_sequencer.sv | 151 +++++++++++++++
 tb/tb_stack_sequencer.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/stack_pkg.sv
// rtl/stack_pkg.sv - shared op codes, default stack bounds and FSM state type
package stack_pkg;

   localparam logic [1:0] STK_NOP  = 2'b00;
   localparam logic [1:0] STK_PUSH = 2'b01;
   localparam logic [1:0] STK_POP  = 2'b10;
   localparam logic [1:0] STK_LOAD = 2'b11;

   localparam logic [7:0] STK_SP_TOP    = 8'hFF;
   localparam logic [7:0] STK_SP_BOTTOM = 8'hAF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR,
      ST_RD,
      ST_RD_WAIT,
      ST_RESP
   } stk_state_e;

endpackage

// File: rtl/stack_sequencer_if.sv
// rtl/stack_sequencer_if.sv - command/response and data-memory port bundle of the stack sequencer
interface stack_sequencer_if;

   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_op;
   logic [7:0] cmd_data;

   logic       rsp_valid;
   logic [7:0] rsp_data;
   logic       rsp_err;

   logic       cpu_mem_req;
   logic       stk_mem_en;
   logic       mem_we;
   logic [7:0] mem_addr;
   logic [7:0] mem_wdata;
   logic [7:0] mem_rdata;

   // master: decoder plus memory mux side; slave: the sequencer
   modport master (
      output cmd_valid, cmd_op, cmd_data, cpu_mem_req, mem_rdata,
      input  cmd_ready, rsp_valid, rsp_data, rsp_err,
      input  stk_mem_en, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_data, cpu_mem_req, mem_rdata,
      output cmd_ready, rsp_valid, rsp_data, rsp_err,
      output stk_mem_en, mem_we, mem_addr, mem_wdata
   );

endinterface

// File: rtl/stack_sp_reg.sv
// rtl/stack_sp_reg.sv - stack pointer register with inc/dec/load, full/empty flags and LOAD_SP range check
// STACK_GUARD_EN enables the range check; otherwise every load value is accepted.
module stack_sp_reg
   import stack_pkg::*;
#(
   parameter logic [7:0] SP_TOP    = STK_SP_TOP,
   parameter logic [7:0] SP_BOTTOM = STK_SP_BOTTOM
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       inc_i,
   input  logic       dec_i,
   input  logic       load_i,
   input  logic [7:0] load_val_i,
   output logic [7:0] sp_o,
   output logic       full_o,
   output logic       empty_o,
   output logic       load_ok_o
);

   logic [7:0] sp_q;
   logic [7:0] sp_d;

   always_comb begin
      sp_d = sp_q;
      if (load_i) begin
         sp_d = load_val_i;
      end else if (dec_i) begin
         sp_d = sp_q - 8'd1;
      end else if (inc_i) begin
         sp_d = sp_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sp_q <= SP_TOP;
      end else begin
         sp_q <= sp_d;
      end
   end

   assign sp_o    = sp_q;
   assign full_o  = (sp_q == SP_BOTTOM);
   assign empty_o = (sp_q == SP_TOP);

`ifdef STACK_GUARD_EN
   // window test as an offset compare so a top of 8'hFF needs no always-true bound
   localparam logic [7:0] SPAN = SP_TOP - SP_BOTTOM;
   logic [7:0] load_off;
   assign load_off  = load_val_i - SP_BOTTOM;
   assign load_ok_o = (load_off <= SPAN);
`else
   assign load_ok_o = 1'b1;
`endif

endmodule

// File: rtl/stack_sequencer.sv
// rtl/stack_sequencer.sv - PUSH/POP/LOAD_SP sequencer onto the shared data-memory port, CPU has priority
// STACK_GUARD_EN adds LOAD_SP window rejection and the sticky fault flag.
module stack_sequencer
   import stack_pkg::*;
#(
   parameter logic [7:0] SP_TOP    = STK_SP_TOP,
   parameter logic [7:0] SP_BOTTOM = STK_SP_BOTTOM
) (
   input  logic                    clk,
   input  logic                    rst,
   stack_sequencer_if.slave        bus,
   output logic [7:0]              sp,
   output logic                    full,
   output logic                    empty,
   output logic                    fault
);

   stk_state_e state_q, state_d;
   logic [7:0] wdata_q;
   logic [7:0] rsp_data_q;
   logic       err_q;
   logic       accept;
   logic       cmd_err;
   logic       port_free;
   logic       load_ok;
   logic       sp_inc, sp_dec, sp_load;

   stack_sp_reg #(
      .SP_TOP    (SP_TOP),
      .SP_BOTTOM (SP_BOTTOM)
   ) u_sp_reg (
      .clk        (clk),
      .rst        (rst),
      .inc_i      (sp_inc),
      .dec_i      (sp_dec),
      .load_i     (sp_load),
      .load_val_i (bus.cmd_data),
      .sp_o       (sp),
      .full_o     (full),
      .empty_o    (empty),
      .load_ok_o  (load_ok)
   );

   assign bus.cmd_ready = (state_q == ST_IDLE) && !rst;
   assign accept        = bus.cmd_valid && bus.cmd_ready;
   // rst gating keeps an aborted WR/RD from strobing the port in the reset cycle
   assign port_free     = !bus.cpu_mem_req && !rst;
   assign bus.rsp_data  = rsp_data_q;

   always_comb begin
      cmd_err = 1'b0;
      case (bus.cmd_op)
         STK_PUSH: cmd_err = full;
         STK_POP:  cmd_err = empty;
         STK_LOAD: cmd_err = !load_ok;
         default:  cmd_err = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (cmd_err || bus.cmd_op == STK_NOP || bus.cmd_op == STK_LOAD) begin
                  state_d = ST_RESP;
               end else if (bus.cmd_op == STK_PUSH) begin
                  state_d = ST_WR;
               end else begin
                  state_d = ST_RD;
               end
            end
         end
         ST_WR:      if (port_free) state_d = ST_RESP;
         ST_RD:      if (port_free) state_d = ST_RD_WAIT;
         ST_RD_WAIT: state_d = ST_RESP;
         ST_RESP:    state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      bus.stk_mem_en = 1'b0;
      bus.mem_we     = 1'b0;
      bus.mem_addr   = 8'h00;
      bus.mem_wdata  = 8'h00;
      sp_inc         = 1'b0;
      sp_dec         = 1'b0;
      sp_load        = accept && (bus.cmd_op == STK_LOAD) && load_ok;
      case (state_q)
         ST_WR: begin
            if (port_free) begin
               bus.stk_mem_en = 1'b1;
               bus.mem_we     = 1'b1;
               bus.mem_addr   = sp;
               bus.mem_wdata  = wdata_q;
               sp_dec         = 1'b1;
            end
         end
         ST_RD: begin
            if (port_free) begin
               bus.stk_mem_en = 1'b1;
               bus.mem_addr   = sp + 8'd1;
               sp_inc         = 1'b1;
            end
         end
         default: ;
      endcase
      bus.rsp_valid = (state_q == ST_RESP);
      bus.rsp_err   = (state_q == ST_RESP) && err_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wdata_q    <= 8'h00;
         err_q      <= 1'b0;
         rsp_data_q <= 8'h00;
      end else begin
         if (accept) begin
            wdata_q <= bus.cmd_data;
            err_q   <= cmd_err;
         end
         if (state_q == ST_RD_WAIT) begin
            rsp_data_q <= bus.mem_rdata;
         end
      end
   end

`ifdef STACK_GUARD_EN
   logic fault_q;
   always_ff @(posedge clk) begin
      if (rst) begin
         fault_q <= 1'b0;
      end else if (accept && cmd_err) begin
         fault_q <= 1'b1;
      end
   end
   assign fault = fault_q;
`else
   assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_stack_sequencer.sv
// tb/tb_stack_sequencer.sv - self-checking bench for stack_sequencer against a stack reference model
module tb_stack_sequencer;
   import stack_pkg::*;

`ifdef STACK_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] sp;
   logic       full, empty, fault;

   stack_sequencer_if bus ();

   stack_sequencer dut (
      .clk   (clk),
      .rst   (rst),
      .bus   (bus.slave),
      .sp    (sp),
      .full  (full),
      .empty (empty),
      .fault (fault)
   );

   always #5 clk = ~clk;

   int tests_run    = 0;
   int tests_failed = 0;
   int wr_total     = 0;
   int rsp_total    = 0;

   logic [7:0] phys_mem [256] = '{default: 8'h00};
   logic [7:0] ref_mem  [256] = '{default: 8'h00};
   logic [7:0] ref_sp    = 8'hFF;
   logic [7:0] ref_last  = 8'h00;
   logic       ref_fault = 1'b0;

   // data memory: registered read, writes only when the stack owns the port
   always @(posedge clk) begin
      if (bus.stk_mem_en && bus.mem_we) begin
         phys_mem[bus.mem_addr] <= bus.mem_wdata;
         wr_total <= wr_total + 1;
      end
      if (bus.rsp_valid) rsp_total <= rsp_total + 1;
      bus.mem_rdata <= phys_mem[bus.mem_addr];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      bus.cmd_valid = 1'b0;
      bus.cmd_op = STK_NOP;
      bus.cmd_data = 8'h00;
      bus.cpu_mem_req = 1'b0;
      @(posedge clk); #2;
      chk("rst_ready_low", bus.cmd_ready, 0);
      @(posedge clk); #1;
      rst = 1'b0; #1;
      chk("rst_sp", sp, 8'hFF);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_rsp_data", bus.rsp_data, 0);
      chk("rst_rsp_err", bus.rsp_err, 0);
      chk("rst_mem_en", bus.stk_mem_en, 0);
      chk("rst_mem_we", bus.mem_we, 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_mem_wdata", bus.mem_wdata, 0);
      chk("rst_fault", fault, 0);
      chk("rst_ready", bus.cmd_ready, 1);
      ref_sp = 8'hFF;
      ref_last = 8'h00;
      ref_fault = 1'b0;
   endtask

   task automatic do_cmd(input string nm, input logic [1:0] op, input logic [7:0] data,
                         input int stall, input bit hold);
      bit exp_err;
      int exp_lat, exp_wr, exp_rd, n, wait_cnt, wr_seen, rd_seen;
      logic [7:0] exp_addr, exp_wdata, seen_addr, seen_wdata;
      wait_cnt = 0;
      while (bus.cmd_ready !== 1'b1 && wait_cnt < 20) begin
         @(posedge clk); #2;
         wait_cnt++;
      end
      chk({nm, "_ready"}, bus.cmd_ready, 1);
      exp_err = 1'b0; exp_lat = 1; exp_wr = 0; exp_rd = 0;
      exp_addr = 8'h00; exp_wdata = 8'h00;
      case (op)
         STK_PUSH: begin
            if (ref_sp == 8'hAF) exp_err = 1'b1;
            else begin
               exp_wr = 1; exp_addr = ref_sp; exp_wdata = data;
               ref_mem[ref_sp] = data;
               ref_sp = ref_sp - 8'd1;
               exp_lat = 2 + stall;
            end
         end
         STK_POP: begin
            if (ref_sp == 8'hFF) exp_err = 1'b1;
            else begin
               ref_sp = ref_sp + 8'd1;
               exp_rd = 1; exp_addr = ref_sp;
               ref_last = ref_mem[ref_sp];
               exp_lat = 3 + stall;
            end
         end
         STK_LOAD: begin
            if (GUARD && data < 8'hAF) exp_err = 1'b1;
            else ref_sp = data;
         end
         default: ;
      endcase
      if (GUARD && exp_err) ref_fault = 1'b1;

      bus.cmd_valid = 1'b1;
      bus.cmd_op = op;
      bus.cmd_data = data;
      @(posedge clk); #1;
      if (!hold) bus.cmd_valid = 1'b0;
      bus.cpu_mem_req = (stall >= 1); #1;
      n = 1; wr_seen = 0; rd_seen = 0; seen_addr = 8'h00; seen_wdata = 8'h00;
      while (bus.rsp_valid !== 1'b1 && n < 40) begin
         chk({nm, "_busy_ready"}, bus.cmd_ready, 0);
         if (bus.cpu_mem_req) chk({nm, "_stall_en"}, bus.stk_mem_en, 0);
         if (bus.stk_mem_en === 1'b1) begin
            seen_addr = bus.mem_addr;
            if (bus.mem_we === 1'b1) begin
               wr_seen++;
               seen_wdata = bus.mem_wdata;
            end else begin
               rd_seen++;
            end
         end
         @(posedge clk); #1;
         n++;
         bus.cpu_mem_req = (n <= stall); #1;
      end
      bus.cpu_mem_req = 1'b0;
      chk({nm, "_rsp_valid"}, bus.rsp_valid, 1);
      chk({nm, "_latency"}, n, exp_lat);
      chk({nm, "_rsp_err"}, bus.rsp_err, exp_err);
      chk({nm, "_rsp_data"}, bus.rsp_data, ref_last);
      chk({nm, "_sp"}, sp, ref_sp);
      chk({nm, "_full"}, full, ref_sp == 8'hAF);
      chk({nm, "_empty"}, empty, ref_sp == 8'hFF);
      chk({nm, "_fault"}, fault, ref_fault);
      chk({nm, "_writes"}, wr_seen, exp_wr);
      chk({nm, "_reads"}, rd_seen, exp_rd);
      chk({nm, "_addr"}, seen_addr, exp_addr);
      chk({nm, "_wdata"}, seen_wdata, exp_wdata);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int wr_snap, rsp_snap;
      logic [1:0] rop;
      logic [7:0] rdat;

      apply_reset();

      do_cmd("push5a", STK_PUSH, 8'h5A, 0, 1'b0);
      do_cmd("pop5a", STK_POP, 8'h00, 0, 1'b0);
      do_cmd("pop_empty", STK_POP, 8'h00, 0, 1'b0);
      do_cmd("nop", STK_NOP, 8'h00, 0, 1'b0);

      for (int i = 0; i < 80; i++) do_cmd("fill", STK_PUSH, 8'($urandom), 0, 1'b0);
      chk("fill_full", full, 1);
      chk("fill_sp", sp, 8'hAF);
      do_cmd("overflow", STK_PUSH, 8'hEE, 2, 1'b0);
      for (int i = 0; i < 80; i++) do_cmd("drain", STK_POP, 8'h00, 0, 1'b0);
      chk("drain_empty", empty, 1);

      do_cmd("push_stall3", STK_PUSH, 8'hC3, 3, 1'b0);
      do_cmd("pop_stall2", STK_POP, 8'h00, 2, 1'b0);

      do_cmd("load10", STK_LOAD, 8'h10, 0, 1'b0);
      do_cmd("nop_after_load", STK_NOP, 8'h00, 1, 1'b0);

      // reset while a push is held off by the CPU
      @(posedge clk); #2;
      chk("rstwr_ready", bus.cmd_ready, 1);
      wr_snap = wr_total;
      rsp_snap = rsp_total;
      bus.cmd_valid = 1'b1; bus.cmd_op = STK_PUSH; bus.cmd_data = 8'h77;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0; bus.cpu_mem_req = 1'b1; #1;
      chk("rstwr_stall_en", bus.stk_mem_en, 0);
      @(posedge clk); #1;
      rst = 1'b1; #1;
      chk("rstwr_rst_en", bus.stk_mem_en, 0);
      @(posedge clk); #1;
      rst = 1'b0; #1;
      chk("rstwr_idle", bus.cmd_ready, 1);
      chk("rstwr_sp", sp, 8'hFF);
      chk("rstwr_en", bus.stk_mem_en, 0);
      chk("rstwr_rsp", bus.rsp_valid, 0);
      chk("rstwr_fault", fault, 0);
      bus.cpu_mem_req = 1'b0;
      ref_sp = 8'hFF; ref_last = 8'h00; ref_fault = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #2;
         chk("rstwr_quiet_en", bus.stk_mem_en, 0);
      end
      chk("rstwr_no_write", wr_total, wr_snap);
      chk("rstwr_no_rsp", rsp_total, rsp_snap);

      // back-to-back with cmd_valid held high
      do_cmd("b2b_push1", STK_PUSH, 8'h01, 0, 1'b1);
      do_cmd("b2b_push2", STK_PUSH, 8'h02, 0, 1'b1);
      do_cmd("b2b_pop2", STK_POP, 8'h00, 0, 1'b1);
      do_cmd("b2b_pop1", STK_POP, 8'h00, 0, 1'b1);
      bus.cmd_valid = 1'b0;
      chk("b2b_last", bus.rsp_data, 8'h01);

      for (int i = 0; i < 150; i++) begin
         rop = 2'($urandom_range(0, 3));
         if (rop == STK_LOAD && $urandom_range(0, 3) != 0) rdat = 8'($urandom_range(8'hAF, 8'hFF));
         else rdat = 8'($urandom);
         do_cmd("rand", rop, rdat, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
         bus.cmd_valid = 1'b0;
      end

      apply_reset();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
